imem_loader: RTL
================

# imem_loader

Boot-time writer for the instruction memory that the fetch stage reads. It accepts a byte stream through a valid/ready handshake and parses a 16-bit word-count header. It assembles big-endian 32-bit instruction words and writes them to the instruction memory write port at consecutive word-aligned byte addresses. While loading it holds the pipeline frozen; it releases the pipeline once the image is complete.

## Interface
Parameters:
- DEPTH, 256: instruction memory capacity in 32-bit words.
- ADDR_BASE, 32'd0: byte address of the first written word; must be a multiple of 4.

Ports:
- Reset is asynchronous and active-high: one clock `clk`, and `rst` asynchronous active-high.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle pulse; restarts loading from DONE.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  32  byte address, word aligned.
- mem_wdata  output  32  instruction word.
- cpu_freez  output  1  pipeline freeze; high while not DONE.
- done  output  1  image fully loaded.
- overflow  output  1  sticky: header count exceeded DEPTH.

## Operation
- States:
  - HDR_HI: receive the count high byte.
  - HDR_LO: receive the count low byte.
  - DATA: receive payload bytes.
  - DONE: idle.
- Byte transfer occurs when in_valid && in_ready; in_ready is high in HDR_HI, HDR_LO and DATA, and low in DONE.
- HDR_HI: cnt[15:8] <= byte; go to HDR_LO.
- HDR_LO: cnt[7:0] <= byte.
  - Go to DONE if the full count is 0, otherwise to DATA.
  - overflow <= (count > DEPTH).
- DATA:
  - Byte lane counter 0..3.
  - Lane 0 lands in bits [31:24], so the first byte is the MSB (MIPS big-endian).
  - On lane 3: issue a write, increment the word index, and reset the lane to 0.
  - When the word index reaches the count, go to DONE.
- Writes occur only when word index < DEPTH.
  - Words beyond DEPTH are consumed, with no mem_we.
  - The state machine still runs to count.
- mem_addr = ADDR_BASE + (word_index << 2), with 32-bit wrap-around arithmetic. The word index and count are 16 bits wide.
- DONE: cpu_freez=0 and done=1. A reload pulse goes to HDR_HI and clears overflow, done and the word index. reload outside DONE is ignored.
- Memory contents are never cleared by the loader.

## Timing
- Reset values:
  - state = HDR_HI
  - in_ready = 1
  - mem_we = 0, mem_addr = ADDR_BASE, mem_wdata = 0
  - cpu_freez = 1, done = 0, overflow = 0
- mem_we, mem_addr and mem_wdata are registered.
  - They are valid the cycle after the 4th byte of a word is accepted.
  - mem_we is a 1-cycle pulse.
- Back-to-back bytes are accepted every cycle; throughput is 1 word per 4 cycles.
- The DONE transition happens in the same edge as the last write registration, so done and cpu_freez=0 appear in the same cycle as the final mem_we.
- Count 0: done rises the cycle after the low header byte.
- in_valid low stalls the FSM in place; partial word state is retained.
- rst asserted mid-load aborts immediately to reset values. Already-written words remain in memory.
- If reload coincides with rst, rst wins.

## Structure
- Shared package `mips_defs`: state encoding constants (HDR_HI=0, HDR_LO=1, DATA=2, DONE=3) and INSTR_W=32.
- One sub-module: `byte_to_word`, a 4-lane big-endian shift assembler with lane counter and word_ready pulse. The FSM, address generation and overflow logic stay in the top module.

## Test plan
- Stream 00 02 | 20 08 00 05 | 01 09 50 20, no gaps:
  - mem_we at address 0x0 with 0x20080005, then at 0x4 with 0x01095020.
  - done=1 and cpu_freez=0 with the second write.
- Same stream with in_valid toggled every other cycle: identical writes.
  - in_ready stays 1 and the partial word is preserved across gaps.
- Header 00 00: no mem_we; done=1 one cycle after the second byte; in_ready=0 after that.
- DEPTH=2, header 00 03, three words:
  - Writes occur at 0x0 and 0x4 only.
  - The third word is consumed with no mem_we.
  - overflow=1, then done=1.
- rst pulsed after 6 payload bytes:
  - All outputs return to reset values.
  - A fresh 1-word image then loads to address 0x0.
- From DONE, reload pulse then header 00 01 + 4 bytes:
  - cpu_freez=1 the cycle after reload.
  - The word is written at ADDR_BASE, then done=1.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// instruction width and the word-address helper.
package mips_defs;

    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        HDR_HI = 2'd0,
        HDR_LO = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } load_state_t;

    // Byte address of a word index; the sum wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [CNT_W-1:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_to_word.sv
// Four-lane big-endian assembler: the first byte of each group ends up in
// bits [31:24]; word_ready pulses alongside the fourth byte.
module byte_to_word
    import mips_defs::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic [INSTR_W-1:0] word,
    output logic               word_ready
);

    logic [1:0]  lane;
    logic [23:0] hold;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= 2'd0;
            hold <= 24'd0;
        end else if (clear) begin
            lane <= 2'd0;
        end else if (byte_valid) begin
            hold <= {hold[15:0], byte_data};
            lane <= lane + 2'd1;
        end
    end

    // The current byte completes the word combinationally so the top can
    // register the write on the same edge that accepts the fourth byte.
    assign word       = {hold, byte_data};
    assign word_ready = byte_valid && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses a 16-bit word-count header,
// then writes big-endian words at consecutive addresses while freezing the CPU.
module imem_loader
    import mips_defs::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] ADDR_BASE = 32'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic               reload,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_freez,
    output logic               done,
    output logic               overflow
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    load_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   word_idx;
    logic               xfer;
    logic [CNT_W-1:0]   hdr_count;
    logic               in_range;
    logic               last_word;
    logic [INSTR_W-1:0] word;
    logic               word_ready;

    assign xfer      = in_valid && in_ready;
    assign hdr_count = {cnt[15:8], in_data};
    assign in_range  = {16'd0, word_idx} < DEPTH_W;
    assign last_word = (word_idx + 16'd1) == cnt;

    byte_to_word u_b2w (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == DONE),
        .byte_valid (xfer && (state == DATA)),
        .byte_data  (in_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HDR_HI;
            cnt       <= '0;
            word_idx  <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_BASE;
            mem_wdata <= '0;
            cpu_freez <= 1'b1;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (xfer) begin
                        cnt[15:8] <= in_data;
                        state     <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        cnt[7:0] <= in_data;
                        overflow <= {16'd0, hdr_count} > DEPTH_W;
                        if (hdr_count == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_freez <= 1'b0;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_ready) begin
                        // Words past the memory end are still consumed to keep the stream aligned.
                        if (in_range) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_addr(ADDR_BASE, word_idx);
                            mem_wdata <= word;
                        end
                        word_idx <= word_idx + 16'd1;
                        if (last_word) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_freez <= 1'b0;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        state     <= HDR_HI;
                        overflow  <= 1'b0;
                        done      <= 1'b0;
                        word_idx  <= '0;
                        cpu_freez <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= HDR_HI;
            endcase
        end
    end

endmodule
